// File: rtl/ray_generator.sv
// Per-pixel view-ray generator: d = u*x + v*y + F*z in fp32, raster order,
// credit-protected output FIFO so the sampler can stall the stream.
module ray_generator #(
    parameter int          WIDTH       = 320,
    parameter int          HEIGHT      = 180,
    parameter logic [31:0] FOCAL       = 32'h43800000,
    parameter int          MUL_LATENCY = 7,
    parameter int          ADD_LATENCY = 7,
    parameter int          FIFO_DEPTH  = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [2:0][31:0]          x,
    input  logic [2:0][31:0]          y,
    input  logic [2:0][31:0]          z,
    input  logic                      start_in,
    output logic                      busy_out,
    output logic [2:0][31:0]          ray_out,
    output logic [$clog2(WIDTH)-1:0]  ray_col_out,
    output logic [$clog2(HEIGHT)-1:0] ray_row_out,
    output logic                      ray_last_out,
    output logic                      ray_valid_out,
    input  logic                      ray_ready_in
);
    // state | meaning
    // IDLE  | waiting for start_in, basis registers hold previous frame
    // RUN   | issuing pixels while credits remain
    // DRAIN | all pixels issued, waiting for pipeline and FIFO to empty
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int TW = CW + RW + 1;
    localparam int PL = MUL_LATENCY + 2 * ADD_LATENCY;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = $clog2(FIFO_DEPTH + 1);

    // Round-to-nearest-even packer; man carries the hidden bit at [23].
    function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e_in,
                                            input logic [23:0] man, input logic g, input logic st);
        logic [24:0]        r;
        logic signed [9:0]  e;
        r = {1'b0, man} + 25'(g & (st | man[0]));
        e = e_in;
        if (r[24]) begin
            r = r >> 1;
            e = e + 10'sd1;
        end
        if (e <= 0)   return {s, 31'b0};
        if (e >= 255) return {s, 8'hFF, 23'b0};
        return {s, e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       prod;
        logic signed [9:0] e;
        logic              s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        if (prod[47]) return fp_pack(s, e + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
        return fp_pack(s, e, prod[46:23], prod[22], |prod[21:0]);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       hi, lo;
        logic [7:0]        d;
        logic [26:0]       ml, sh;
        logic [27:0]       sum;
        logic signed [9:0] e;
        int                lz;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'b0};
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            hi = a; lo = b;
        end else begin
            hi = b; lo = a;
        end
        d  = hi[30:23] - lo[30:23];
        ml = {1'b1, lo[22:0], 3'b0};
        if (d > 8'd26) begin
            sh = 27'd1;
        end else begin
            sh = ml >> d;
            if ((ml & ((27'd1 << d) - 27'd1)) != 27'd0) sh[0] = 1'b1;
        end
        e = $signed({2'b0, hi[30:23]});
        if (hi[31] == lo[31]) begin
            sum = {2'b01, hi[22:0], 3'b0} + {1'b0, sh};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 10'sd1;
            end
        end else begin
            sum = {2'b01, hi[22:0], 3'b0} - {1'b0, sh};
            if (sum == 28'd0) return 32'h0;
            lz = 0;
            for (int i = 0; i < 27; i++) if (sum[i]) lz = 26 - i;
            sum = sum << lz;
            e   = e - 10'(lz);
        end
        return fp_pack(hi[31], e, sum[26:3], sum[2], |sum[1:0]);
    endfunction

    function automatic logic [31:0] int_to_fp(input logic signed [31:0] n);
        logic [31:0] mag;
        logic [31:0] res;
        int          pos;
        mag = n[31] ? 32'(-n) : 32'(n);
        res = '0;
        pos = 0;
        for (int i = 0; i < 24; i++) if (mag[i]) pos = i;
        if (mag != 32'd0) begin
            res[31]    = n[31];
            res[30:23] = 8'(127 + pos);
            res[22:0]  = 23'(mag << (23 - pos));
        end
        return res;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                           state;
    logic [CW-1:0]                    col;
    logic [RW-1:0]                    row;
    logic [KW-1:0]                    credits;
    logic [2:0][31:0]                 bx, by, bz;
    logic                             issue, pop, push;
    logic                             s0_valid;
    logic [31:0]                      s0_u, s0_v;
    logic [TW-1:0]                    s0_tag;
    logic [MUL_LATENCY-1:0][8:0][31:0] mul_pipe;
    logic [ADD_LATENCY-1:0][5:0][31:0] add1_pipe;
    logic [ADD_LATENCY-1:0][2:0][31:0] add2_pipe;
    logic [PL-1:0]                    vld_pipe;
    logic [PL-1:0][TW-1:0]            tag_pipe;
    logic [96+TW-1:0]                 mem [FIFO_DEPTH];
    logic [96+TW-1:0]                 head;
    logic [AW-1:0]                    wr_ptr, rd_ptr;
    logic [KW-1:0]                    count;

    assign issue = (state == RUN) && (credits != '0);
    assign pop   = ray_valid_out && ray_ready_in;
    assign push  = vld_pipe[PL-1];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            col      <= '0;
            row      <= '0;
            bx       <= '0;
            by       <= '0;
            bz       <= '0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    bx       <= x;
                    by       <= y;
                    bz       <= z;
                    col      <= '0;
                    row      <= '0;
                    busy_out <= 1'b1;
                    state    <= RUN;
                end
                RUN: if (issue) begin
                    if (col == CW'(WIDTH - 1)) begin
                        col <= '0;
                        if (row == RW'(HEIGHT - 1)) begin
                            row   <= '0;
                            state <= DRAIN;
                        end else begin
                            row <= row + RW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                // Only one credit outstanding means this pop empties the frame.
                DRAIN: if (pop && credits == KW'(FIFO_DEPTH - 1)) begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            credits  <= KW'(FIFO_DEPTH);
            s0_valid <= 1'b0;
            vld_pipe <= '0;
        end else begin
            if (issue && !pop)      credits <= credits - KW'(1);
            else if (!issue && pop) credits <= credits + KW'(1);
            s0_valid <= issue;
            vld_pipe <= {vld_pipe[PL-2:0], s0_valid};
        end
    end

    // Datapath registers carry no reset; stale contents are masked by vld_pipe.
    always_ff @(posedge clk_in) begin
        s0_u   <= int_to_fp(int'(col) - WIDTH / 2);
        s0_v   <= int_to_fp(HEIGHT / 2 - int'(row));
        s0_tag <= {(col == CW'(WIDTH - 1)) && (row == RW'(HEIGHT - 1)), row, col};
        tag_pipe[0] <= s0_tag;
        for (int i = 1; i < PL; i++) tag_pipe[i] <= tag_pipe[i-1];
        for (int k = 0; k < 3; k++) begin
            mul_pipe[0][k]   <= fp_mul(s0_u, bx[k]);
            mul_pipe[0][k+3] <= fp_mul(s0_v, by[k]);
            mul_pipe[0][k+6] <= fp_mul(FOCAL, bz[k]);
            add1_pipe[0][k]   <= fp_add(mul_pipe[MUL_LATENCY-1][k], mul_pipe[MUL_LATENCY-1][k+3]);
            add1_pipe[0][k+3] <= mul_pipe[MUL_LATENCY-1][k+6];
            add2_pipe[0][k]   <= fp_add(add1_pipe[ADD_LATENCY-1][k], add1_pipe[ADD_LATENCY-1][k+3]);
        end
        for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
        for (int i = 1; i < ADD_LATENCY; i++) begin
            add1_pipe[i] <= add1_pipe[i-1];
            add2_pipe[i] <= add2_pipe[i-1];
        end
        if (push) mem[wr_ptr] <= {add2_pipe[ADD_LATENCY-1], tag_pipe[PL-1]};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            if (push && !pop)      count <= count + KW'(1);
            else if (!push && pop) count <= count - KW'(1);
        end
    end

    assign head          = mem[rd_ptr];
    assign ray_valid_out = (count != '0);
    assign ray_out       = ray_valid_out ? head[96+TW-1:TW] : '0;
    assign ray_last_out  = ray_valid_out & head[TW-1];
    assign ray_row_out   = ray_valid_out ? head[CW+RW-1:CW] : '0;
    assign ray_col_out   = ray_valid_out ? head[CW-1:0] : '0;
endmodule

// File: tb/tb_ray_generator.sv
// Bench for ray_generator: real-arithmetic ray model, per-pop compare, latency,
// busy timing, backpressure, mid-frame restart and async reset scenarios.
module tb_ray_generator;
    // Reduced frame keeps every scenario well inside the cycle budget.
    localparam int W = 40, H = 20, NPIX = W * H;
    localparam int CW = $clog2(W), RW = $clog2(H);

    logic             clk = 0, rst_n = 1, start = 0, ready = 1;
    logic [2:0][31:0] x = '0, y = '0, z = '0;
    logic             busy, last, valid;
    logic [2:0][31:0] ray;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;

    ray_generator #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .x(x), .y(y), .z(z), .start_in(start),
        .busy_out(busy), .ray_out(ray), .ray_col_out(col), .ray_row_out(row),
        .ray_last_out(last), .ray_valid_out(valid), .ray_ready_in(ready));

    always #5 clk = ~clk;

    typedef struct {logic [95:0] d; int c; int r; logic l;} ray_t;
    ray_t               expq[$];
    ray_t               exp_r;
    logic [95:0]        got [NPIX];
    int                 n_pass = 0, n_total = 0, cyc = 0, pop_cnt = 0, last_pop_cyc = -1;
    bit                 rand_ready = 0, hold = 0;
    logic [95+TW_F():0] held;
    logic [2:0][31:0]   id_x, id_y, id_z, yaw_x, alt_x, alt_y, alt_z, r2_x, r2_y, r2_z;

    function automatic int TW_F();
        return CW + RW + 1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h, required %0h", name, act, req);
    endtask

    function automatic real fp_to_real(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        real         a;
        int          e;
        logic [31:0] b;
        if (r == 0.0) return 32'h0;
        a = (r < 0.0) ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        b[31]    = (r < 0.0);
        b[30:23] = 8'(e);
        b[22:0]  = 23'($rtoi((a - 1.0) * 8388608.0));
        return b;
    endfunction

    function automatic logic [31:0] rnd_comp();
        return real_to_fp((real'($urandom_range(0, 32)) - 16.0) / 8.0);
    endfunction

    task automatic gen_frame(input logic [2:0][31:0] bx, input logic [2:0][31:0] by,
                             input logic [2:0][31:0] bz);
        ray_t r;
        for (int rr = 0; rr < H; rr++)
            for (int cc = 0; cc < W; cc++) begin
                for (int k = 0; k < 3; k++)
                    r.d[k*32 +: 32] = real_to_fp(real'(cc - W/2) * fp_to_real(bx[k])
                                               + real'(H/2 - rr) * fp_to_real(by[k])
                                               + 256.0 * fp_to_real(bz[k]));
                r.c = cc;
                r.r = rr;
                r.l = (cc == W-1) && (rr == H-1);
                expq.push_back(r);
            end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_ray", ray, 0);
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
    endtask

    task automatic run_frame(input logic [2:0][31:0] bx, input logic [2:0][31:0] by,
                             input logic [2:0][31:0] bz, input bit mid);
        int n;
        expq.delete();
        pop_cnt = 0;
        last_pop_cyc = -1;
        gen_frame(bx, by, bz);
        @(posedge clk); #2;
        x = bx; y = by; z = bz;
        chk("busy_idle", busy, 0);
        start = 1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start = 0;
                chk("busy_rise", busy, 1);
            end
        end while (!valid && n < 60);
        chk("first_valid_latency", n, 24);
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (mid && n == 150) begin
                x = alt_x; y = alt_y; z = alt_z;
                start = 1;
            end
            if (mid && n == 151) start = 0;
        end
        chk("busy_timeout", busy, 0);
        chk("ray_count", pop_cnt, NPIX);
        chk("model_drained", expq.size(), 0);
        chk("busy_fall_cycle", cyc, last_pop_cyc + 1);
    endtask

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk); #2;
        ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", valid, 1);
                chk("hold_stable", {ray, row, col, last}, held);
            end
            hold = 0;
            if (valid) begin
                if (ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_ray", valid, 0);
                    end else begin
                        exp_r = expq.pop_front();
                        chk("ray_data", ray, exp_r.d);
                        chk("ray_col", col, exp_r.c);
                        chk("ray_row", row, exp_r.r);
                        chk("ray_last", last, exp_r.l);
                    end
                    if (int'(row) * W + int'(col) < NPIX) got[int'(row) * W + int'(col)] = ray;
                    pop_cnt++;
                    if (last) last_pop_cyc = cyc;
                end else begin
                    hold = 1;
                    held = {ray, row, col, last};
                end
            end
        end
    end

    initial begin
        int n;
        id_x  = {32'h0, 32'h0, 32'h3F800000};
        id_y  = {32'h0, 32'h3F800000, 32'h0};
        id_z  = {32'h3F800000, 32'h0, 32'h0};
        yaw_x = {32'hBF800000, 32'h0, 32'h0};
        for (int k = 0; k < 3; k++) begin
            alt_x[k] = rnd_comp(); alt_y[k] = rnd_comp(); alt_z[k] = rnd_comp();
            r2_x[k]  = rnd_comp(); r2_y[k]  = rnd_comp(); r2_z[k]  = rnd_comp();
        end

        #2 rst_n = 0;
        #1 chk_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Pin the model with hand-computed rays.
        gen_frame(id_x, id_y, id_z);
        chk("model_first", expq[0].d, {32'h43800000, 32'h41200000, 32'hC1A00000});
        chk("model_center", expq[10*W+20].d, {32'h43800000, 32'h0, 32'h0});
        chk("model_last", expq[NPIX-1].d, {32'h43800000, 32'hC1100000, 32'h41980000});
        expq.delete();

        rand_ready = 0;
        run_frame(id_x, id_y, id_z, 0);
        chk("id_first", got[0], {32'h43800000, 32'h41200000, 32'hC1A00000});
        chk("id_center", got[10*W+20], {32'h43800000, 32'h0, 32'h0});
        chk("id_last", got[NPIX-1], {32'h43800000, 32'hC1100000, 32'h41980000});

        rand_ready = 1;
        run_frame(id_x, id_y, id_z, 1);
        run_frame(alt_x, alt_y, alt_z, 0);

        rand_ready = 0;
        run_frame(yaw_x, id_y, id_x, 0);
        chk("yaw_first", got[0], {32'h41A00000, 32'h41200000, 32'h43800000});

        expq.delete();
        pop_cnt = 0;
        gen_frame(r2_x, r2_y, r2_z);
        @(posedge clk); #2;
        x = r2_x; y = r2_y; z = r2_z;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        n = 0;
        while (pop_cnt < 500 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_point_reached", pop_cnt >= 500, 1);
        @(posedge clk); #3;
        rst_n = 0;
        #1 chk_reset_outputs();
        expq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;

        run_frame(id_x, id_y, id_z, 0);
        chk("post_reset_first", got[0], {32'h43800000, 32'h41200000, 32'hC1A00000});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
